// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        RUN   = 2'd3
    } boot_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          WORD_SHIFT       = 2;

endpackage

// File: rtl/imem_boot_ctrl_flush_timer.sv
// Down-counter that holds the pipeline flush for a fixed number of cycles.
module flush_timer #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: streams a program into instruction memory with fetch stalled,
// flushes the pipeline, forces the start PC and releases the core.
//
// state | meaning
// IDLE  | out of reset, core held, waiting for start
// LOAD  | accepting program words into consecutive imem words
// FLUSH | pipeline flush held for FLUSH_CYCLES cycles
// RUN   | core executing; start requests a reload
module imem_boot_ctrl
    import riscv_pkg::*;
#(
    parameter int          ADDR_WIDTH   = 5,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int          FLUSH_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  imem_we,
    output logic [31:0]           imem_addr,
    output logic [DATA_WIDTH-1:0] imem_wd,
    output logic                  StallF,
    output logic                  flush_pipe,
    output logic                  pc_init,
    output logic                  core_run,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  overflow
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int TW    = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

    boot_state_t state;
    logic        accept;
    logic        at_last_idx;
    logic        load_done;
    logic        timer_zero;

    assign load_ready  = (state == LOAD);
    assign accept      = load_ready && load_valid;
    assign at_last_idx = (load_count == CW'(DEPTH - 1));
    assign load_done   = accept && (load_last || at_last_idx);

    assign imem_we   = accept;
    assign imem_addr = RESET_PC + (32'(load_count) << WORD_SHIFT);
    assign imem_wd   = load_data;

    flush_timer #(
        .WIDTH(TW)
    ) u_flush_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (load_done),
        .en        (state == FLUSH),
        .load_value(TW'(FLUSH_CYCLES - 1)),
        .zero      (timer_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            StallF     <= 1'b1;
            flush_pipe <= 1'b1;
            pc_init    <= 1'b1;
            core_run   <= 1'b0;
            load_count <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        load_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        load_count <= load_count + CW'(1);
                        if (load_last) begin
                            state <= FLUSH;
                        end else if (at_last_idx) begin
                            // image filled the memory without a terminating word
                            overflow <= 1'b1;
                            state    <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (timer_zero) begin
                        state      <= RUN;
                        StallF     <= 1'b0;
                        flush_pipe <= 1'b0;
                        pc_init    <= 1'b0;
                        core_run   <= 1'b1;
                    end
                end
                RUN: begin
                    if (start) begin
                        state      <= LOAD;
                        StallF     <= 1'b1;
                        flush_pipe <= 1'b1;
                        pc_init    <= 1'b1;
                        core_run   <= 1'b0;
                        load_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Directed/randomized bench for imem_boot_ctrl with an abstract load model.
module tb_imem_boot_ctrl;

    localparam int          AW     = 5;
    localparam int          DW     = 32;
    localparam int          DEPTH  = 32;
    localparam logic [31:0] RPC    = 32'h0000_0000;
    localparam int          NFLUSH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [DW-1:0] load_data = '0;
    logic          load_last = 1'b0;
    logic          imem_we;
    logic [31:0]   imem_addr;
    logic [DW-1:0] imem_wd;
    logic          StallF, flush_pipe, pc_init, core_run, overflow;
    logic [AW:0]   load_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] fixed_words [0:2];

    imem_boot_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC), .FLUSH_CYCLES(NFLUSH)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
        .StallF(StallF), .flush_pipe(flush_pipe), .pc_init(pc_init),
        .core_run(core_run), .load_count(load_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive at the falling edge, settle, then the caller samples
    task automatic cycle(input logic v, input logic [31:0] d, input logic l, input logic s);
        @(negedge clk);
        load_valid = v;
        load_data  = d;
        load_last  = l;
        start      = s;
        #1;
    endtask

    task automatic chk_held(input string tag, input logic exp_held);
        chk({tag, "_stallf"}, {31'd0, StallF}, {31'd0, exp_held});
        chk({tag, "_flush"},  {31'd0, flush_pipe}, {31'd0, exp_held});
        chk({tag, "_pcinit"}, {31'd0, pc_init}, {31'd0, exp_held});
        chk({tag, "_run"},    {31'd0, core_run}, {31'd0, !exp_held});
    endtask

    task automatic start_load(input bit from_run);
        cycle(1'b0, 32'd0, 1'b0, 1'b1);
        chk("start_ready", {31'd0, load_ready}, 32'd0);
        chk_held("start_cyc", !from_run);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        chk("entry_ready", {31'd0, load_ready}, 32'd1);
        chk_held("entry", 1'b1);
        chk("entry_count", 32'(load_count), 32'd0);
        chk("entry_ovf", {31'd0, overflow}, 32'd0);
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random
    task automatic run_load(input bit from_run, input int n_words, input bit has_last,
                            input int vmode, input bit use_fixed, input bit hold_start,
                            input bit start_in_flush);
        int          idx = 0;
        int          cyc = 0;
        bit          done = 0;
        bit          last_seen = 0;
        logic        v, l;
        logic [31:0] d;
        start_load(from_run);
        while (!done && cyc < 300) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = ((cyc % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            d = use_fixed ? fixed_words[idx % 3] : $urandom;
            l = has_last && (idx == n_words - 1);
            cycle(v, d, l, hold_start);
            chk("ld_ready", {31'd0, load_ready}, 32'd1);
            chk("ld_we", {31'd0, imem_we}, {31'd0, v});
            chk("ld_count", 32'(load_count), 32'(idx));
            chk_held("ld", 1'b1);
            if (v) begin
                chk("ld_addr", imem_addr, RPC + 32'(4 * idx));
                chk("ld_wd", imem_wd, d);
                idx++;
                if (l) last_seen = 1;
                if (l || idx == DEPTH) done = 1;
            end
            cyc++;
        end
        if (!done) chk("ld_timeout", 32'd1, 32'd0);
        for (int k = 1; k <= NFLUSH; k++) begin
            cycle(1'b1, $urandom, 1'b0, start_in_flush && (k == 2));
            chk("fl_ready", {31'd0, load_ready}, 32'd0);
            chk("fl_we", {31'd0, imem_we}, 32'd0);
            chk_held("fl", 1'b1);
            chk("fl_count", 32'(load_count), 32'(idx));
            chk("fl_ovf", {31'd0, overflow}, {31'd0, (idx == DEPTH) && !last_seen});
        end
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        chk_held("run", 1'b0);
        chk("run_count", 32'(load_count), 32'(idx));
        chk("run_ovf", {31'd0, overflow}, {31'd0, (idx == DEPTH) && !last_seen});
        chk("run_ready", {31'd0, load_ready}, 32'd0);
        cycle(1'b0, 32'd0, 1'b0, 1'b0);
        chk_held("run2", 1'b0);
    endtask

    initial begin
        fixed_words[0] = 32'h0050_0093;
        fixed_words[1] = 32'h0010_0113;
        fixed_words[2] = 32'h0020_81B3;

        #12;
        chk_held("rst", 1'b1);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_count", 32'(load_count), 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // three-word program, core released FLUSH_CYCLES+1 after last accept
        run_load(1'b0, 3, 1'b1, 0, 1'b1, 1'b0, 1'b0);
        // gapped stream
        run_load(1'b1, 4, 1'b1, 1, 1'b0, 1'b0, 1'b0);
        // full image without load_last
        run_load(1'b1, DEPTH, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        // reload from RUN clears overflow
        run_load(1'b1, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0);

        // asynchronous reset part way through a load
        start_load(1'b1);
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        chk("mid_count", 32'(load_count), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk_held("async_rst", 1'b1);
        chk("arst_ready", {31'd0, load_ready}, 32'd0);
        chk("arst_we", {31'd0, imem_we}, 32'd0);
        chk("arst_count", 32'(load_count), 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_load(1'b0, 5, 1'b1, 2, 1'b0, 1'b0, 1'b0);

        // start held through LOAD and pulsed in FLUSH
        run_load(1'b1, 6, 1'b1, 2, 1'b0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
